// File: rtl/hdmi_pio_pkg.sv
// Shared definitions for the HDMI control PIO: register addresses,
// edge-capture mode encodings and the pulse state machine states.
package hdmi_pio_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_IRQMASK = 3'd1;
    localparam logic [2:0] ADDR_EDGECAP = 3'd2;
    localparam logic [2:0] ADDR_OUTVAL  = 3'd3;
    localparam logic [2:0] ADDR_SET     = 3'd4;
    localparam logic [2:0] ADDR_CLEAR   = 3'd5;
    localparam logic [2:0] ADDR_PULSE   = 3'd6;
    localparam logic [2:0] ADDR_STATUS  = 3'd7;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    typedef enum logic {
        PS_IDLE,
        PS_ACTIVE
    } pulse_state_e;

endpackage

// File: rtl/hdmi_ctrl_pio_if.sv
// Avalon-MM slave bus bundle for the HDMI control PIO.
//   address    : register select (3 bits)
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data (WIDTH bits)
//   readdata   : combinational read data (WIDTH bits), zero wait states
interface hdmi_ctrl_pio_if #(
    parameter int WIDTH = 8
);
    logic [2:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [WIDTH-1:0] writedata;
    logic [WIDTH-1:0] readdata;

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );
endinterface

// File: rtl/hdmi_ctrl_pio_edge_sync.sv
// Input conditioning for the PIO status inputs: 2-flop synchroniser,
// one extra delay stage, and a per-bit edge detector.
//   clk, reset : system clock, async active-high reset
//   async_in   : asynchronous status inputs
//   in_sync    : synchronised copy (2 cycles latency)
//   edge_det   : one-cycle edge strobes selected by EDGE_TYPE
module hdmi_pio_edge_sync
    import hdmi_pio_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int EDGE_TYPE = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] in_sync,
    output logic [WIDTH-1:0] edge_det
);

    logic [WIDTH-1:0] s1, s2, s3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign in_sync = s2;

    always_comb begin
        edge_det = '0;
        case (EDGE_TYPE)
            EDGE_FALL: edge_det = ~s2 & s3;
            EDGE_ANY:  edge_det = s2 ^ s3;
            default:   edge_det = s2 & ~s3;
        endcase
    end

endmodule

// File: rtl/hdmi_ctrl_pio.sv
// HDMI control PIO: Avalon-MM slave with a WIDTH-bit output port supporting
// atomic set/clear and self-timed pulses, plus a synchronised input port
// with edge capture and a maskable level interrupt.
//   clk, reset : system clock, async active-high reset
//   bus        : Avalon-MM slave (address/chipselect/write_n/writedata/readdata)
//   in_port    : asynchronous status inputs (HPD, PLL lock, ...)
//   out_port   : control outputs, straight from the data_out register
//   irq        : registered level interrupt, |(edge_cap & irq_mask)
module hdmi_ctrl_pio
    import hdmi_pio_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
    parameter int               PULSE_CYCLES = 1024,
    parameter int               EDGE_TYPE    = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset,
    hdmi_ctrl_pio_if.slave   bus,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    localparam int CNT_W = $clog2(PULSE_CYCLES + 1);

    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] pulse_mask;
    logic [CNT_W-1:0] pulse_cnt;
    pulse_state_e     state;

    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] edge_det;

    logic             wr;
    logic             pulse_wr;
    logic             expire;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] data_nxt;

    hdmi_pio_edge_sync #(
        .WIDTH     (WIDTH),
        .EDGE_TYPE (EDGE_TYPE)
    ) u_edge_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (in_port),
        .in_sync  (in_sync),
        .edge_det (edge_det)
    );

    assign wr       = bus.chipselect & ~bus.write_n;
    assign pulse_wr = wr && (bus.address == ADDR_PULSE) && (bus.writedata != '0);
    assign expire   = (state == PS_ACTIVE) && (pulse_cnt == '0) && !pulse_wr;
    assign edge_clr = (wr && (bus.address == ADDR_EDGECAP)) ? bus.writedata : '0;

    // Expiry clear is applied first so a same-cycle bus write wins on the bits it touches.
    always_comb begin
        data_nxt = expire ? (data_out & ~pulse_mask) : data_out;
        if (wr) begin
            case (bus.address)
                ADDR_DATA:  data_nxt = bus.writedata;
                ADDR_SET:   data_nxt = data_nxt | bus.writedata;
                ADDR_CLEAR: data_nxt = data_nxt & ~bus.writedata;
                ADDR_PULSE: data_nxt = data_nxt | bus.writedata;
                default:    ;
            endcase
        end
    end

    // Pulse state machine; data_out lives here so out_port stays a bare flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= PS_IDLE;
            pulse_mask <= '0;
            pulse_cnt  <= '0;
            data_out   <= RESET_VALUE;
        end else begin
            data_out <= data_nxt;
            if (pulse_wr) begin
                state      <= PS_ACTIVE;
                pulse_mask <= pulse_mask | bus.writedata;
                pulse_cnt  <= CNT_W'(PULSE_CYCLES - 1);
            end else begin
                case (state)
                    PS_ACTIVE: begin
                        if (pulse_cnt != '0) begin
                            pulse_cnt <= pulse_cnt - 1'b1;
                        end else begin
                            pulse_mask <= '0;
                            state      <= PS_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // A new edge wins over a same-cycle write-1-to-clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_mask <= '0;
            edge_cap <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr && (bus.address == ADDR_IRQMASK))
                irq_mask <= bus.writedata;
            edge_cap <= (edge_cap & ~edge_clr) | edge_det;
            irq      <= |(edge_cap & irq_mask);
        end
    end

    assign out_port = data_out;

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_DATA:    bus.readdata = in_sync;
            ADDR_IRQMASK: bus.readdata = irq_mask;
            ADDR_EDGECAP: bus.readdata = edge_cap;
            ADDR_OUTVAL:  bus.readdata = data_out;
            ADDR_PULSE:   bus.readdata = pulse_mask;
            ADDR_STATUS:  bus.readdata[0] = (state == PS_ACTIVE);
            default:      ;
        endcase
    end

endmodule

// File: tb/tb_hdmi_ctrl_pio.sv
// Bench for hdmi_ctrl_pio: directed scenarios with literal expectations plus
// randomized bus/input traffic, all compared against a behavioural model.
module tb_hdmi_ctrl_pio;

    localparam int         W  = 8;
    localparam logic [7:0] RV = 8'h01;
    localparam int         P  = 16;
    localparam int         ET = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] in_port = 8'h00;
    logic [7:0] out_port;
    logic       irq;
    bit         run = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    hdmi_ctrl_pio_if #(.WIDTH(W)) bus ();

    hdmi_ctrl_pio #(
        .WIDTH        (W),
        .RESET_VALUE  (RV),
        .PULSE_CYCLES (P),
        .EDGE_TYPE    (ET)
    ) dut (
        .clk      (clk),
        .reset    (rst),
        .bus      (bus),
        .in_port  (in_port),
        .out_port (out_port),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    // Behavioural model: register contents, remaining pulse lifetime in cycles,
    // and the in_port values sampled at the last three clock edges.
    logic [7:0] m_d, m_mask, m_ec, m_pm;
    int         m_rem;
    bit         m_irq;
    logic [7:0] hist [3];

    function automatic void m_reset();
        m_d = RV; m_mask = 8'h00; m_ec = 8'h00; m_pm = 8'h00;
        m_rem = 0; m_irq = 1'b0;
        for (int i = 0; i < 3; i++) hist[i] = 8'h00;
    endfunction

    function automatic void m_update(input bit wr, input logic [2:0] a,
                                     input logic [7:0] wd, input logic [7:0] pin);
        bit         pwr;
        logic [7:0] edg;
        bit         irq_n;
        pwr = wr && (a == 3'd6) && (wd != 8'h00);
        // hist[1] is the value visible as in_sync, hist[2] the one before it
        case (ET)
            1:       edg = ~hist[1] & hist[2];
            2:       edg = hist[1] ^ hist[2];
            default: edg = hist[1] & ~hist[2];
        endcase
        irq_n = |(m_ec & m_mask);
        if (!pwr && m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
                m_d  = m_d & ~m_pm;
                m_pm = 8'h00;
            end
        end
        if (wr) begin
            case (a)
                3'd0: m_d = wd;
                3'd1: m_mask = wd;
                3'd4: m_d = m_d | wd;
                3'd5: m_d = m_d & ~wd;
                3'd6: if (wd != 8'h00) begin
                    m_d = m_d | wd; m_pm = m_pm | wd; m_rem = P;
                end
                default: ;
            endcase
        end
        m_ec  = (m_ec & ~((wr && a == 3'd2) ? wd : 8'h00)) | edg;
        m_irq = irq_n;
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = pin;
    endfunction

    function automatic logic [7:0] exp_rd(input logic [2:0] a);
        case (a)
            3'd0:    return hist[1];
            3'd1:    return m_mask;
            3'd2:    return m_ec;
            3'd3:    return m_d;
            3'd6:    return m_pm;
            3'd7:    return (m_rem > 0) ? 8'h01 : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Single compare process: every cycle, DUT outputs vs. model.
    always @(negedge clk) begin
        if (run) begin
            check("out_port", {24'h0, out_port}, {24'h0, m_d});
            check("irq", {31'h0, irq}, {31'h0, m_irq});
            check("readdata", {24'h0, bus.readdata}, {24'h0, exp_rd(bus.address)});
        end
    end

    task automatic tick();
        @(posedge clk);
        if (rst) m_reset();
        else m_update(bus.chipselect & ~bus.write_n, bus.address, bus.writedata, in_port);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
        tick();
        bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 8'h00;
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] exp, input string name);
        bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
        #1;
        check(name, {24'h0, bus.readdata}, {24'h0, exp});
        bus.chipselect = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.address = 3'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 8'h00;
        m_reset();
        #1 rst = 1'b1;
        ticks(2);
        run = 1'b1;
        check("reset out_port", {24'h0, out_port}, 32'h01);
        check("reset irq", {31'h0, irq}, 32'h0);
        rst = 1'b0;
        ticks(3);

        // Set / clear
        bus_write(3'd0, 8'hA5);
        check("data out", {24'h0, out_port}, 32'hA5);
        rd(3'd3, 8'hA5, "outval data");
        bus_write(3'd4, 8'h0A);
        check("set out", {24'h0, out_port}, 32'hAF);
        rd(3'd3, 8'hAF, "outval set");
        bus_write(3'd5, 8'h81);
        check("clear out", {24'h0, out_port}, 32'h2E);
        rd(3'd3, 8'h2E, "outval clear");

        // Single pulse: exactly P cycles high
        bus_write(3'd0, 8'h00);
        bus_write(3'd6, 8'h03);
        for (int i = 0; i < P; i++) begin
            check("pulse high", {30'h0, out_port[1:0]}, 32'h3);
            rd(3'd7, 8'h01, "pulse busy");
            tick();
        end
        check("pulse done", {24'h0, out_port}, 32'h00);
        rd(3'd7, 8'h00, "pulse idle");

        // Re-trigger at cycle 10 extends all bits
        bus_write(3'd6, 8'h03);
        ticks(9);
        bus_write(3'd6, 8'h04);
        for (int i = 0; i < P; i++) begin
            check("retrig high", {29'h0, out_port[2:0]}, 32'h7);
            tick();
        end
        check("retrig done", {24'h0, out_port}, 32'h00);

        // SET on the expiry cycle wins
        bus_write(3'd6, 8'h01);
        ticks(P - 1);
        bus_write(3'd4, 8'h01);
        check("expiry set out", {31'h0, out_port[0]}, 32'h1);
        rd(3'd6, 8'h00, "expiry pulse_mask");
        rd(3'd7, 8'h00, "expiry status");
        bus_write(3'd5, 8'hFF);

        // Reset mid-pulse
        bus_write(3'd6, 8'h10);
        ticks(3);
        #2 rst = 1'b1;
        m_reset();
        #1;
        check("async reset out", {24'h0, out_port}, 32'h01);
        check("async reset irq", {31'h0, irq}, 32'h0);
        tick();
        for (int a = 0; a < 8; a++)
            rd(3'(a), (a == 3) ? 8'h01 : 8'h00, "reset regs");
        rst = 1'b0;
        ticks(2);

        // Edge capture and interrupt
        bus_write(3'd1, 8'h01);
        in_port = 8'h01;
        ticks(2);
        rd(3'd2, 8'h00, "edgecap early");
        tick();
        rd(3'd2, 8'h01, "edgecap 3 cycles");
        check("irq not yet", {31'h0, irq}, 32'h0);
        tick();
        check("irq cycle 4", {31'h0, irq}, 32'h1);
        in_port = 8'h03;
        ticks(3);
        rd(3'd2, 8'h03, "edgecap bit1 unmasked");
        check("irq held", {31'h0, irq}, 32'h1);
        bus_write(3'd2, 8'h01);
        rd(3'd2, 8'h02, "edgecap cleared");
        tick();
        check("irq dropped", {31'h0, irq}, 32'h0);

        // Clear / edge collision
        in_port = 8'h02; ticks(4);
        in_port = 8'h03; ticks(4);
        rd(3'd2, 8'h03, "edgecap reset up");
        in_port = 8'h02; ticks(4);
        in_port = 8'h03;
        ticks(2);
        bus_write(3'd2, 8'h01);
        rd(3'd2, 8'h03, "collision edge wins");
        tick();
        check("collision irq", {31'h0, irq}, 32'h1);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            logic [2:0] a;
            logic [7:0] d;
            a = 3'($urandom_range(0, 7));
            d = 8'($urandom);
            if ($urandom_range(0, 9) == 0) in_port = in_port ^ (8'h01 << $urandom_range(0, 7));
            if (c == 1500) begin
                #2 rst = 1'b1;
                m_reset();
                tick();
                rst = 1'b0;
            end else if ($urandom_range(0, 99) < 25) begin
                if (a == 3'd6 && $urandom_range(0, 3) != 0) a = 3'd3;
                if (a == 3'd6 && $urandom_range(0, 3) == 0) d = 8'h00;
                bus_write(a, d);
            end else begin
                bus.address = a;
                tick();
            end
        end
        ticks(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
